// File: rtl/uart_tx_engine.sv
// 8-bit UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// tx is registered from the next-state logic, so it changes on the same edge as the FSM state.
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_tx,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_overrun
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic              r_overrun;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_data;

    state_t            w_state_next;
    logic              w_tx_next;
    logic              w_done_next;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        w_idx_next;
    logic [7:0]        w_data_next;
    logic              w_bit_end;
    logic [2:0]        w_idx_inc;

    assign w_bit_end = (r_baud == BAUD_MAX);
    assign w_idx_inc = r_bit_idx + 3'd1;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_done_next  = 1'b0;
        w_baud_next  = r_baud;
        w_idx_next   = r_bit_idx;
        w_data_next  = r_data;

        if (r_state != S_IDLE) begin
            w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (new_tx) begin
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                    w_data_next  = tx_data;
                    w_idx_next   = 3'd0;
                    w_baud_next  = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_tx_next    = r_data[0];
                    w_idx_next   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        if (PARITY_EN) begin
                            w_state_next = S_PARITY;
                            w_tx_next    = ^r_data;
                        end else begin
                            w_state_next = S_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_idx_next = w_idx_inc;
                        w_tx_next  = r_data[w_idx_inc];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                    w_tx_next    = 1'b1;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_data    <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_tx      <= w_tx_next;
            r_busy    <= (w_state_next != S_IDLE);
            r_done    <= w_done_next;
            r_overrun <= new_tx & r_busy;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_idx_next;
            r_data    <= w_data_next;
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign tx_done    = r_done;
    assign tx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine at CLKS_PER_BIT=4, one instance without and one with parity.
// Outputs are sampled on the falling edge; index k holds the value seen just before rising edge k.
module tb_uart_tx_engine;

    localparam int CPB  = 4;
    localparam int MAXE = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       n_new_tx, p_new_tx;
    logic [7:0] n_tx_data, p_tx_data;
    logic       n_tx, n_busy, n_done, n_ovr;
    logic       p_tx, p_busy, p_done, p_ovr;

    always #5 clk = ~clk;

    uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .new_tx(n_new_tx), .tx_data(n_tx_data),
        .tx(n_tx), .busy(n_busy), .tx_done(n_done), .tx_overrun(n_ovr)
    );

    uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n), .new_tx(p_new_tx), .tx_data(p_tx_data),
        .tx(p_tx), .busy(p_busy), .tx_done(p_done), .tx_overrun(p_ovr)
    );

    typedef struct {
        logic        par;
        logic [7:0]  data;
        logic [0:10] seq;       // line bits in transmit order, start bit first
        int          nbits;
        int          done_edge;
    } vec_t;

    vec_t vecs[5];

    int errors = 0;
    int checks = 0;

    logic [MAXE:0] rec_tx, rec_busy, rec_done, rec_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ones(input logic [MAXE:0] v, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (v[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic drive(input logic par, input logic nt, input logic [7:0] d);
        if (par) begin
            p_new_tx  = nt;
            p_tx_data = d;
            n_new_tx  = 1'b0;
        end else begin
            n_new_tx  = nt;
            n_tx_data = d;
            p_new_tx  = 1'b0;
        end
    endtask

    // Call just after a falling edge: the request lands on the next rising edge (edge 0).
    task automatic capture(input logic par, input int len, input logic [7:0] d0,
                           input int hold, input int edge2, input logic [7:0] d2);
        rec_tx = '1; rec_busy = '0; rec_done = '0; rec_ovr = '0;
        drive(par, 1'b1, d0);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            rec_tx[k]   = par ? p_tx   : n_tx;
            rec_busy[k] = par ? p_busy : n_busy;
            rec_done[k] = par ? p_done : n_done;
            rec_ovr[k]  = par ? p_ovr  : n_ovr;
            if (k == edge2) drive(par, 1'b1, d2);
            else            drive(par, k < hold, ~d0);
        end
        drive(par, 1'b0, ~d0);
    endtask

    task automatic check_frame(input string tag, input logic [0:10] seq, input int nbits, input int first);
        for (int b = 0; b < nbits; b++) begin
            logic [3:0] act;
            for (int c = 0; c < CPB; c++) act[c] = rec_tx[first + b*CPB + c];
            check($sformatf("%s bit%0d", tag, b), 32'(act), 32'({4{seq[b]}}));
        end
    endtask

    initial begin
        int first_done;
        int second_done;
        int rst_done;

        vecs[0] = '{1'b0, 8'hA5, 11'b01010010111, 10, 41};
        vecs[1] = '{1'b0, 8'h00, 11'b00000000011, 10, 41};
        vecs[2] = '{1'b0, 8'hFF, 11'b01111111111, 10, 41};
        vecs[3] = '{1'b1, 8'hA5, 11'b01010010101, 11, 45};
        vecs[4] = '{1'b1, 8'h07, 11'b01110000011, 11, 45};

        rst_n = 1'b0;
        n_new_tx = 1'b0; p_new_tx = 1'b0;
        n_tx_data = 8'h00; p_tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst n_tx", 32'(n_tx), 32'(1));
        check("rst n_busy", 32'(n_busy), 32'(0));
        check("rst n_done", 32'(n_done), 32'(0));
        check("rst n_ovr", 32'(n_ovr), 32'(0));
        check("rst p_tx", 32'(p_tx), 32'(1));
        check("rst p_busy", 32'(p_busy), 32'(0));
        rst_n = 1'b1;

        // The first vector starts on the first edge after reset release.
        for (int i = 0; i < 5; i++) begin
            int len;
            string tag;
            len = vecs[i].done_edge + 3;
            tag = $sformatf("vec%0d_%02h_p%0d", i, vecs[i].data, vecs[i].par);
            capture(vecs[i].par, len, vecs[i].data, 1, -1, 8'h00);
            check_frame(tag, vecs[i].seq, vecs[i].nbits, 1);
            check({tag, " busy@1"}, 32'(rec_busy[1]), 32'(1));
            check({tag, " busy@end-1"}, 32'(rec_busy[vecs[i].done_edge - 1]), 32'(1));
            check({tag, " busy@end"}, 32'(rec_busy[vecs[i].done_edge]), 32'(0));
            check({tag, " busy count"}, 32'(ones(rec_busy, 1, len)), 32'(vecs[i].done_edge - 1));
            check({tag, " done edge"}, 32'(rec_done[vecs[i].done_edge]), 32'(1));
            check({tag, " done count"}, 32'(ones(rec_done, 1, len)), 32'(1));
            check({tag, " ovr count"}, 32'(ones(rec_ovr, 1, len)), 32'(0));
            check({tag, " idle after"}, 32'(rec_tx[vecs[i].done_edge]), 32'(1));
        end

        // Second request at edge 10 is ignored; only 0x3C goes out.
        capture(1'b0, 44, 8'h3C, 1, 10, 8'hFF);
        check_frame("ovr_3c", 11'b00011110011, 10, 1);
        check("ovr pulse@11", 32'(rec_ovr[11]), 32'(1));
        check("ovr count", 32'(ones(rec_ovr, 1, 44)), 32'(1));
        check("ovr done@41", 32'(rec_done[41]), 32'(1));
        check("ovr done count", 32'(ones(rec_done, 1, 44)), 32'(1));

        // Request in the tx_done cycle (edge 41) starts the next frame at once.
        capture(1'b0, 85, 8'hA5, 1, 41, 8'h55);
        check_frame("b2b_a5", 11'b01010010111, 10, 1);
        check("b2b tx@41", 32'(rec_tx[41]), 32'(1));
        check_frame("b2b_55", 11'b01010101011, 10, 42);
        first_done = -1;
        second_done = -1;
        for (int k = 1; k <= 85; k++) begin
            if (rec_done[k] === 1'b1) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        check("b2b done count", 32'(ones(rec_done, 1, 85)), 32'(2));
        check("b2b first done", 32'(first_done), 32'(41));
        check("b2b gap cycles", 32'(second_done - first_done - 1), 32'(40));
        check("b2b ovr count", 32'(ones(rec_ovr, 1, 85)), 32'(0));

        // new_tx held for three cycles: one frame, two overrun cycles.
        capture(1'b0, 44, 8'h81, 3, -1, 8'h00);
        check_frame("held_81", 11'b01000000111, 10, 1);
        check("held ovr@2", 32'(rec_ovr[2]), 32'(1));
        check("held ovr@3", 32'(rec_ovr[3]), 32'(1));
        check("held ovr count", 32'(ones(rec_ovr, 1, 44)), 32'(2));
        check("held done count", 32'(ones(rec_done, 1, 44)), 32'(1));

        // Reset asserted mid-frame, between clock edges.
        capture(1'b0, 15, 8'h00, 1, -1, 8'h00);
        @(posedge clk);
        #1;
        check("mid pre tx", 32'(n_tx), 32'(0));
        check("mid pre busy", 32'(n_busy), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid async tx", 32'(n_tx), 32'(1));
        check("mid async busy", 32'(n_busy), 32'(0));
        rst_done = ones(rec_done, 1, 15);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (n_done === 1'b1) rst_done++;
        end
        check("mid no done", 32'(rst_done), 32'(0));
        rst_n = 1'b1;
        capture(1'b0, 44, 8'hA5, 1, -1, 8'h00);
        check_frame("post_rst_a5", 11'b01010010111, 10, 1);
        check("post_rst done@41", 32'(rec_done[41]), 32'(1));
        check("post_rst done count", 32'(ones(rec_done, 1, 44)), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
